// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the load/store unit.
// Multi-byte accesses are split into consecutive little-endian byte transfers.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d, cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  function automatic logic [2:0] size_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [RAM_AW-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0] k);
    return RAM_AW'(base + ADDR_W'(k));
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  logic [2:0]  nxt;
  logic [1:0]  prev_idx;
  logic [31:0] rd_word;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
    nxt         = cnt_q + 3'd1;
    prev_idx    = cnt_q[1:0] - 2'd1;
    // ram_din carries the byte addressed in the previous cycle
    rd_word     = (cnt_q != 3'd0) ? put_byte(buf_q, prev_idx, ram_din) : buf_q;

    case (state_q)
      IDLE: begin
        ram_addr_d = '0;
        ram_wr_d   = 1'b0;
        if (mem_req) begin
          base_d     = mem_addr;
          n_d        = size_of(mem_sel);
          wdata_d    = mem_wdata;
          cnt_d      = 3'd0;
          buf_d      = '0;
          ram_addr_d = byte_addr(mem_addr, 3'd0);
          if (mem_we) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req && !if_abort) begin
          base_d     = if_addr;
          n_d        = 3'd4;
          cnt_d      = 3'd0;
          buf_d      = '0;
          ram_addr_d = byte_addr(if_addr, 3'd0);
          state_d    = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && if_abort) begin
          state_d    = IDLE;
          ram_addr_d = '0;
        end else begin
          buf_d = rd_word;
          if (nxt < n_q) ram_addr_d = byte_addr(base_q, nxt);
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = rd_word;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rd_word;
            end
          end else begin
            cnt_d = nxt;
          end
        end
      end
      MEM_WR: begin
        if (nxt < n_q) begin
          cnt_d      = nxt;
          ram_addr_d = byte_addr(base_q, nxt);
          ram_dout_d = pick_byte(wdata_q, nxt[1:0]);
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = DONE;
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        ram_addr_d = '0;
        ram_wr_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  mem_arbiter #(.ADDR_W(32), .RAM_AW(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency; pre_* lets the bench preload it.
  logic [7:0]  ram [0:131071];
  logic        pre_en = 1'b0;
  logic [16:0] pre_addr = '0;
  logic [7:0]  pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_val;
    else if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: the active transaction and how many cycles since its grant.
  logic [7:0]  ref_mem [0:131071];
  int          m_act = 0;  // 0 none, 1 IF read, 2 MEM read, 3 MEM write
  int          m_off = 0;
  int          m_n = 0;
  logic [31:0] m_base = '0, m_wd = '0, m_rbuf = '0;
  logic [31:0] m_if_data = '0, m_mem_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic int size_of(input logic [1:0] sel);
    return (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
  endfunction

  task automatic cmp_step();
    bit          e_ifd, e_md, e_wr;
    logic [31:0] ea;
    e_ifd = (m_act == 1) && (m_off == 6);
    e_md  = ((m_act == 2) && (m_off == m_n + 2)) || ((m_act == 3) && (m_off == m_n + 1));
    e_wr  = (m_act == 3) && (m_off >= 1) && (m_off <= m_n);
    ea    = m_base + 32'(m_off - 1);
    if (chk_en) begin
      chk("if_done", {31'b0, if_done}, {31'b0, e_ifd});
      chk("mem_done", {31'b0, mem_done}, {31'b0, e_md});
      chk("ram_wr", {31'b0, ram_wr}, {31'b0, e_wr});
      if (m_act == 0)
        chk("ram_addr_idle", {15'b0, ram_addr}, 32'h0);
      else if (m_off >= 1 && m_off <= m_n)
        chk("ram_addr", {15'b0, ram_addr}, {15'b0, ea[16:0]});
      if (e_wr) chk("ram_dout", {24'b0, ram_dout}, {24'b0, m_wd[8*(m_off-1) +: 8]});
      chk("if_data", if_data, e_ifd ? m_rbuf : m_if_data);
      chk("mem_rdata", mem_rdata, (e_md && m_act == 2) ? m_rbuf : m_mem_rdata);
    end
    if (pre_en) ref_mem[pre_addr] = pre_val;
    if (e_wr) ref_mem[ea[16:0]] = m_wd[8*(m_off-1) +: 8];
    if (e_ifd) m_if_data = m_rbuf;
    if (e_md && m_act == 2) m_mem_rdata = m_rbuf;
    if (rst) begin
      m_act = 0; m_if_data = '0; m_mem_rdata = '0;
    end else if (m_act == 0) begin
      if (mem_req) begin
        m_act = mem_we ? 3 : 2; m_n = size_of(mem_sel); m_base = mem_addr; m_wd = mem_wdata;
      end else if (if_req && !if_abort) begin
        m_act = 1; m_n = 4; m_base = if_addr;
      end
      if (m_act != 0) begin
        m_off = 1;
        m_rbuf = '0;
        for (int k = 0; k < m_n; k++) begin
          logic [31:0] a;
          a = m_base + 32'(k);
          m_rbuf[8*k +: 8] = ref_mem[a[16:0]];
        end
      end
    end else if (e_ifd || e_md) begin
      m_act = 0;
    end else if (m_act == 1 && if_abort) begin
      m_act = 0;
    end else begin
      m_off++;
    end
  endtask

  // One clock: check/advance at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cmp_step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] v);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic wait_done(input bit want_if, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (want_if ? if_done : mem_done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit saw;
    logic [16:0] seq [4];

    rst = 1'b1; if_req = 0; if_addr = 0; if_abort = 0;
    mem_req = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ram_addr", {15'b0, ram_addr}, 32'h0);
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    chk("rst_if_done", {31'b0, if_done}, 32'h0);
    chk("rst_mem_done", {31'b0, mem_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    preload(17'h100, 8'h13); preload(17'h101, 8'h00);
    preload(17'h102, 8'h50); preload(17'h103, 8'h00);
    preload(17'h300, 8'h11); preload(17'h301, 8'h22);
    preload(17'h302, 8'h33); preload(17'h303, 8'h44);
    preload(17'h200, 8'hEF); preload(17'h201, 8'hBE);
    preload(17'h202, 8'hAD); preload(17'h203, 8'hDE);
    preload(17'h21, 8'h11);
    for (int i = 0; i < 4; i++) preload(17'h40 + 17'(i), 8'h00);
    preload(17'h1FFFE, 8'hAA); preload(17'h1FFFF, 8'hBB);
    preload(17'h00000, 8'hCC); preload(17'h00001, 8'hDD);

    // Word fetch
    if_req = 1; if_addr = 32'h100;
    wait_done(1, 20, lat);
    if_req = 0;
    chk("fetch_latency", lat, 6);
    chk("fetch_data", if_data, 32'h00500013);
    tick();

    // Byte store, then half and byte loads
    mem_req = 1; mem_we = 1; mem_sel = 0; mem_addr = 32'h20; mem_wdata = 32'hAABBCCDD;
    wait_done(0, 20, lat);
    mem_req = 0; mem_we = 0;
    chk("store_latency", lat, 2);
    chk("store_ram_byte", {24'b0, ram[17'h20]}, 32'hDD);
    tick();
    mem_req = 1; mem_sel = 1; mem_addr = 32'h20;
    wait_done(0, 20, lat);
    mem_req = 0;
    chk("half_latency", lat, 4);
    chk("half_data", mem_rdata, 32'h000011DD);
    tick();
    mem_req = 1; mem_sel = 0; mem_addr = 32'h20;
    wait_done(0, 20, lat);
    mem_req = 0;
    chk("byte_latency", lat, 3);
    chk("byte_data", mem_rdata, 32'h000000DD);
    tick();

    // Contention: MEM wins, IF follows
    mem_req = 1; mem_sel = 2; mem_addr = 32'h300; if_req = 1; if_addr = 32'h100;
    wait_done(0, 20, lat);
    mem_req = 0;
    chk("contend_mem_latency", lat, 6);
    chk("contend_mem_data", mem_rdata, 32'h44332211);
    wait_done(1, 20, lat);
    if_req = 0;
    chk("contend_if_latency", lat, 7);
    chk("contend_if_data", if_data, 32'h00500013);
    tick();

    // Abort at t+3, new fetch at t+4
    if_req = 1; if_addr = 32'h100; saw = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      saw |= if_done;
    end
    if_abort = 1;
    tick();
    saw |= if_done;
    if_abort = 0; if_addr = 32'h200;
    chk("abort_no_done", {31'b0, saw}, 32'h0);
    chk("abort_data_held", if_data, 32'h00500013);
    wait_done(1, 20, lat);
    if_req = 0;
    chk("refetch_latency", lat, 6);
    chk("refetch_data", if_data, 32'hDEADBEEF);
    tick();

    // Reset in the middle of a word store
    mem_req = 1; mem_we = 1; mem_sel = 3; mem_addr = 32'h40; mem_wdata = 32'h87654321;
    saw = 0;
    tick();
    saw |= mem_done;
    tick();
    saw |= mem_done;
    rst = 1; mem_req = 0; mem_we = 0;
    tick();
    rst = 0;
    chk("rst_mid_ram_wr", {31'b0, ram_wr}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      saw |= mem_done;
      tick();
    end
    chk("rst_mid_no_done", {31'b0, saw}, 32'h0);
    chk("rst_mid_byte0", {24'b0, ram[17'h40]}, 32'h21);
    chk("rst_mid_byte1", {24'b0, ram[17'h41]}, 32'h43);
    chk("rst_mid_byte2", {24'b0, ram[17'h42]}, 32'h00);
    chk("rst_mid_byte3", {24'b0, ram[17'h43]}, 32'h00);

    // Address wrap
    mem_req = 1; mem_sel = 2; mem_addr = 32'hFFFFFFFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = ram_addr;
    end
    chk("wrap_addr0", {15'b0, seq[0]}, 32'h1FFFE);
    chk("wrap_addr1", {15'b0, seq[1]}, 32'h1FFFF);
    chk("wrap_addr2", {15'b0, seq[2]}, 32'h00000);
    chk("wrap_addr3", {15'b0, seq[3]}, 32'h00001);
    wait_done(0, 20, lat);
    mem_req = 0;
    chk("wrap_latency", lat, 2);
    chk("wrap_data", mem_rdata, 32'hDDCCBBAA);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store unit (MEM stage).
Multi-byte accesses are sequenced as consecutive byte transfers; little-endian words are assembled and disassembled here.
Each requester gets a one-cycle done pulse.
While a requester waits for done, the pipeline control stalls the upstream stages and the EX/MEM and MEM/WB registers.

Parameters:
ADDR_W, 32, width of requester addresses.
RAM_AW, 17, width of the RAM address; ram_addr carries the low RAM_AW bits of the computed byte address.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_req  in  1  IF requests a 4-byte instruction read; held until if_done
if_addr  in  ADDR_W  IF byte address
if_abort  in  1  cancels an in-flight IF read (branch redirect)
if_done  out  1  one-cycle pulse; if_data valid in the same cycle
if_data  out  32  fetched instruction
mem_req  in  1  MEM requests an access; held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_sel  in  2  0 = byte, 1 = half, 2 or 3 = word
mem_addr  in  ADDR_W  MEM byte address
mem_wdata  in  32  store data; low bytes used
mem_done  out  1  one-cycle pulse
mem_rdata  out  32  load data, zero-extended; valid with mem_done
ram_addr  out  RAM_AW  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write data
ram_din  in  8  RAM read data; valid one cycle after its address

Behaviour:
- Reset: rst is synchronous, active-high, clock is clk. On reset, all outputs are 0 and the state is IDLE. Reset during any transfer returns to IDLE on that edge, with no done pulse and ram_wr = 0.
- States:
  - IDLE: drives ram_addr = 0, ram_wr = 0.
  - IF_RD, MEM_RD, MEM_WR: transfer states.
  - DONE: single cycle; asserts the relevant done.
- Grant: sampled in IDLE only.
  - mem_req has priority over if_req, because the MEM instruction is older.
  - On grant, latch the address, size N, we and wdata into internal registers. Later changes to the requester inputs are ignored until done.
  - N = 1, 2 or 4; IF always uses N = 4.
- Read sequence (request seen in IDLE at cycle t):
  - Cycles t+1 .. t+N: ram_addr = base + k, for k = 0 .. N-1.
  - Byte k is captured from ram_din at cycle t+2+k into bits [8k+7:8k]; unused upper bytes are 0.
  - Done pulses at cycle t+N+2, e.g. a word read has done at t+6.
- Write sequence:
  - Cycles t+1 .. t+N: ram_wr = 1, ram_addr = base + k, ram_dout = wdata[8k+7:8k].
  - Done at t+N+1; ram_wr = 0 in the done cycle.
- Addresses: arithmetic wraps modulo 2^ADDR_W before truncation to RAM_AW. Unaligned addresses are legal; the block has no alignment check.
- DONE cycle: the state returns to IDLE; requests are not sampled in the DONE cycle. The earliest next grant is DONE+1, where MEM still wins a tie.
- if_abort:
  - In IF_RD: return to IDLE on the next edge; no if_done; if_data is unchanged.
  - In IDLE: blocks an IF grant in that cycle.
  - Ignored in MEM states; never affects a MEM access.
- Data hold: if_data and mem_rdata hold their last value between done pulses.
- Done exclusivity: if_done and mem_done are never high in the same cycle.

Test Plan:
- Word fetch: reset; if_req = 1, if_addr = 0x100, RAM[0x100..0x103] = 13,00,50,00 → ram_addr 0x100..0x103 on t+1..t+4; if_done at t+6 with if_data = 0x00500013.
- Byte store then half load: mem_we = 1, mem_sel = 0, mem_addr = 0x20, mem_wdata = 0xAABBCCDD → a single ram_wr at t+1 with ram_dout = 0xDD and mem_done at t+2. Then mem_sel = 1 read of 0x20 with RAM[0x21] = 0x11 → mem_rdata = 0x000011DD.
- Contention: if_req and mem_req both raised in the same IDLE cycle, MEM word read → MEM served first with mem_done at t+6. IF is granted at t+7 and completes at t+13.
- Abort: if_abort pulsed at t+3 of an IF read → no if_done. The arbiter is back in IDLE at t+4; a new if_req at 0x200 completes 6 cycles after its grant.
- Reset mid-write: rst asserted at t+2 of a word store → ram_wr = 0 from the next edge, no mem_done, and only byte 0 (plus byte 1 if its edge was reached) is written.
- Wrap: mem word read at 0xFFFFFFFE with RAM_AW = 17 → ram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
